// File: rtl/present_pkg.sv
// Shared PRESENT key-schedule definitions: S-box, mode/state enums and the
// one-round key update used by the sequential round-key generator.
package present_pkg;

    localparam int RK_W   = 64;   // round-key width
    localparam int IDX_W  = 6;    // round index 1..32 needs six bits
    localparam int ADDR_W = 5;    // round-key buffer address (index - 1)
    localparam int DEPTH  = 32;   // round-key buffer entries

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_REV = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD    = 2'd1,
        EXPAND = 2'd2,
        REV    = 2'd3
    } state_e;

    // One key-schedule step. The key sits right-aligned in a 128-bit
    // container so both key widths share a single function; for the 80-bit
    // schedule the upper 48 bits of the result are always zero.
    function automatic logic [127:0] present_key_update(
        input logic [127:0] key,
        input logic [4:0]   r,
        input int           key_w
    );
        logic [127:0] k;
        k = '0;
        if (key_w == 80) begin
            k[79:0]    = {key[18:0], key[79:19]};
            k[79:76]   = SBOX[k[79:76]];
            k[19:15]   = k[19:15] ^ r;
        end else begin
            k          = {key[66:0], key[127:67]};
            k[127:124] = SBOX[k[127:124]];
            k[123:120] = SBOX[k[123:120]];
            k[66:62]   = k[66:62] ^ r;
        end
        return k;
    endfunction

endpackage

// File: rtl/present_key_expander_if.sv
// Key-load request and round-key stream bundle of the PRESENT key expander.
interface present_key_expander_if
    import present_pkg::*;
#(
    parameter int KEY_W = 80
);
    logic [KEY_W-1:0] key_in;
    logic             key_load;
    logic             mode;
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  rk_data;
    logic [IDX_W-1:0] rk_idx;
    logic             busy;
    logic             done;

    // Key-load source and round-key consumer side
    modport master (
        output key_in, key_load, mode, rk_ready,
        input  rk_valid, rk_data, rk_idx, busy, done
    );

    // Key expander side
    modport slave (
        input  key_in, key_load, mode, rk_ready,
        output rk_valid, rk_data, rk_idx, busy, done
    );
endinterface

// File: rtl/present_rk_buf.sv
// 32x64 round-key register file: one synchronous write port, one
// combinational read port. Storage is deliberately not reset.
module present_rk_buf
    import present_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [RK_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [RK_W-1:0]   rdata
);
    logic [RK_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/present_key_expander.sv
// Sequential PRESENT round-key generator for 80/128-bit keys. Forward mode
// streams K1..K(N+1) straight from the key register; reverse mode first
// expands every round key into a buffer, then streams K(N+1)..K1 from it.
module present_key_expander
    import present_pkg::*;
#(
    parameter int KEY_W      = 80,
    parameter int NUM_ROUNDS = 31
) (
    input logic                   clk,
    input logic                   rst_n,
    present_key_expander_if.slave bus
);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_key_expander: KEY_W must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
        $error("present_key_expander: NUM_ROUNDS must be 1..31");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS + 1);

    state_e            state, state_next;
    logic [127:0]      key_reg, key_next, key_upd;
    logic [IDX_W-1:0]  counter, counter_next;
    logic              done_reg, done_next;
    logic              buf_we;
    logic              valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [RK_W-1:0]   key_top, buf_rdata;

    assign key_top  = key_reg[KEY_W-1 -: RK_W];
    assign key_upd  = present_key_update(key_reg, counter[4:0], KEY_W);
    assign buf_addr = ADDR_W'(counter - 1'b1);

    present_rk_buf u_rk_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_addr),
        .wdata (key_top),
        .raddr (buf_addr),
        .rdata (buf_rdata)
    );

    // State, key and counter registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_reg  <= '0;
            counter  <= '0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            key_reg  <= key_next;
            counter  <= counter_next;
            done_reg <= done_next;
        end
    end

    // Next-state, key update and stream control
    always_comb begin
        state_next   = state;
        key_next     = key_reg;
        counter_next = counter;
        done_next    = 1'b0;
        buf_we       = 1'b0;
        valid        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.key_load) begin
                    key_next     = 128'(bus.key_in);
                    counter_next = IDX_W'(1);
                    state_next   = (mode_e'(bus.mode) == MODE_FWD) ? FWD : EXPAND;
                end
            end
            FWD: begin
                valid = 1'b1;
                if (bus.rk_ready) begin
                    if (counter == LAST_IDX) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        key_next     = key_upd;
                        counter_next = counter + 1'b1;
                    end
                end
            end
            EXPAND: begin
                // The last buffered key needs no further update, so the
                // counter is left at LAST_IDX for the reverse stream.
                buf_we = 1'b1;
                if (counter == LAST_IDX) begin
                    state_next = REV;
                end else begin
                    key_next     = key_upd;
                    counter_next = counter + 1'b1;
                end
            end
            REV: begin
                valid = 1'b1;
                if (bus.rk_ready) begin
                    if (counter == IDX_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        counter_next = counter - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rk_valid = valid;
    assign bus.rk_data  = !valid ? '0 : ((state == REV) ? buf_rdata : key_top);
    assign bus.rk_idx   = valid ? counter : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_present_key_expander.sv
// Self-checking bench for present_key_expander (80- and 128-bit instances).
module tb_present_key_expander;

    localparam logic [3:0] SB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [127:0] MASK80 = (128'd1 << 80) - 128'd1;
    localparam logic [63:0]  K2_80  = 64'hC000000000000000;
    localparam logic [63:0]  K3_80  = 64'h5000180000000001;
    localparam logic [63:0]  K2_128 = 64'hCC00000000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    present_key_expander_if #(.KEY_W(80))  if80  ();
    present_key_expander_if #(.KEY_W(128)) if128 ();

    present_key_expander #(.KEY_W(80), .NUM_ROUNDS(31)) dut80 (
        .clk(clk), .rst_n(rst_n), .bus(if80.slave));
    present_key_expander #(.KEY_W(128), .NUM_ROUNDS(31)) dut128 (
        .clk(clk), .rst_n(rst_n), .bus(if128.slave));

    int passed, total;

    logic [63:0] got_key [$];
    logic [5:0]  got_idx [$];
    logic [63:0] exp_keys [1:32];
    int lat, done_cnt, stab_err, last_hs, timed_out;
    logic done_final, busy_final;

    // Reference schedule: all 32 round keys from the update rules, using
    // shift-and-mask rotation on a plain 128-bit number.
    task automatic compute_ref(input logic [127:0] key, input int kw);
        logic [127:0] k;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            exp_keys[i] = (kw == 80) ? k[79:16] : k[127:64];
            if (kw == 80) begin
                k = ((k << 61) | (k >> 19)) & MASK80;
                k[79:76] = SB[k[79:76]];
                k[19:15] ^= 5'(i);
            end else begin
                k = (k << 61) | (k >> 67);
                k[127:124] = SB[k[127:124]];
                k[123:120] = SB[k[123:120]];
                k[66:62] ^= 5'(i);
            end
        end
    endtask

    // Number of stream entries that disagree with exp_keys in the given order
    function automatic int seq_errors(input bit rev);
        int e;
        int ei;
        e = 0;
        if (got_key.size() != 32) return 99;
        for (int i = 0; i < 32; i++) begin
            ei = rev ? 32 - i : i + 1;
            if (got_idx[i] !== 6'(ei) || got_key[i] !== exp_keys[ei]) e++;
        end
        return e;
    endfunction

    // Drives one run on the 80-bit instance and records what it streams.
    task automatic collect80(input logic [79:0] key, input logic md, input int stall_pct,
                             input int force_idx, input int inject_idx, input int stop_cyc,
                             input bit no_wait);
        int cyc, forced;
        bit held, injected, rdy;
        logic [63:0] hd;
        logic [5:0]  hi;
        got_key.delete();
        got_idx.delete();
        lat = -1; done_cnt = 0; stab_err = 0; last_hs = -1; timed_out = 0;
        done_final = 1'b0; busy_final = 1'b1;
        cyc = 0; forced = 0; held = 0; injected = 0; hd = '0; hi = '0;
        if (!no_wait) @(negedge clk);
        if80.key_in = key;
        if80.mode = md;
        if80.key_load = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if80.key_load = 1'b0;
            if80.key_in = 80'({$urandom(), $urandom(), $urandom()});
            if (cyc == stop_cyc) return;
            if (if80.done) done_cnt++;
            if (last_hs >= 0 && cyc == last_hs + 1) begin
                done_final = if80.done;
                busy_final = if80.busy;
                return;
            end
            if (cyc > 400) begin
                timed_out = 1;
                return;
            end
            if (held && (!if80.rk_valid || if80.rk_data !== hd || if80.rk_idx !== hi)) stab_err++;
            held = 0;
            rdy = ($urandom_range(99) >= 32'(stall_pct));
            if (if80.rk_valid) begin
                if (lat < 0) lat = cyc;
                if (if80.rk_idx == 6'(force_idx) && forced < 5) begin
                    rdy = 0;
                    forced++;
                end
                if (!injected && inject_idx > 0 && if80.rk_idx == 6'(inject_idx)) begin
                    injected = 1;
                    if80.key_load = 1'b1;
                    if80.key_in = ~key;
                    if80.mode = ~md;
                end
                if (rdy) begin
                    got_key.push_back(if80.rk_data);
                    got_idx.push_back(if80.rk_idx);
                    if (got_key.size() == 32) last_hs = cyc;
                end else begin
                    held = 1;
                    hd = if80.rk_data;
                    hi = if80.rk_idx;
                end
            end
            if80.rk_ready = rdy;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (if80.rk_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if80.rk_valid); else passed++;
        total++; if (if80.rk_data !== 64'd0) $display("FAIL reset_data: got %h expected 0", if80.rk_data); else passed++;
        total++; if (if80.rk_idx !== 6'd0) $display("FAIL reset_idx: got %0d expected 0", if80.rk_idx); else passed++;
        total++; if (if80.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", if80.busy); else passed++;
        total++; if (if80.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", if80.done); else passed++;
        total++; if ({if128.rk_valid, if128.busy, if128.done} !== 3'b000)
            $display("FAIL reset_128: got %b expected 000", {if128.rk_valid, if128.busy, if128.done}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwd_vectors;
        logic [63:0] k3;
        collect80(80'd0, 1'b0, 0, 0, 0, 0, 1'b0);
        compute_ref(128'd0, 80);
        k3 = (got_key.size() > 2) ? got_key[2] : 64'hx;
        total++; if (timed_out != 0) $display("FAIL fwd_timeout: got %0d expected 0", timed_out); else passed++;
        total++; if (lat != 1) $display("FAIL fwd_latency: got %0d expected 1", lat); else passed++;
        total++; if (got_key.size() != 32) $display("FAIL fwd_count: got %0d expected 32", got_key.size()); else passed++;
        total++; if (got_key.size() < 1 || got_key[0] !== 64'd0) $display("FAIL fwd_k1: got %h expected 0", got_key.size() ? got_key[0] : 64'hx); else passed++;
        total++; if (got_key.size() < 2 || got_key[1] !== K2_80) $display("FAIL fwd_k2: got %h expected %h", got_key.size() > 1 ? got_key[1] : 64'hx, K2_80); else passed++;
        total++; if (k3 !== K3_80) $display("FAIL fwd_k3: got %h expected %h", k3, K3_80); else passed++;
        total++; if (seq_errors(1'b0) != 0) $display("FAIL fwd_seq: got %0d bad keys expected 0", seq_errors(1'b0)); else passed++;
        total++; if (last_hs != 32) $display("FAIL fwd_rate: got last handshake cycle %0d expected 32", last_hs); else passed++;
        total++; if (done_cnt != 1 || done_final !== 1'b1) $display("FAIL fwd_done: got pulses %0d final %b expected 1 1", done_cnt, done_final); else passed++;
        total++; if (busy_final !== 1'b0) $display("FAIL fwd_busy_end: got %b expected 0", busy_final); else passed++;
        @(negedge clk);
        total++; if (if80.done !== 1'b0) $display("FAIL fwd_done_width: got %b expected 0", if80.done); else passed++;
    endtask

    task automatic test_128;
        logic [127:0] key;
        int cyc;
        bit seen_done;
        for (int run = 0; run < 2; run++) begin
            key = (run == 0) ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()};
            got_key.delete();
            got_idx.delete();
            @(negedge clk);
            if128.key_in = key;
            if128.mode = run[0];
            if128.key_load = 1'b1;
            if128.rk_ready = 1'b1;
            cyc = 0;
            seen_done = 0;
            while (cyc < 120 && !seen_done) begin
                @(negedge clk);
                cyc++;
                if128.key_load = 1'b0;
                if (if128.done) seen_done = 1;
                if (if128.rk_valid) begin
                    got_key.push_back(if128.rk_data);
                    got_idx.push_back(if128.rk_idx);
                end
            end
            compute_ref(key, 128);
            total++; if (!seen_done) $display("FAIL k128_done: got no done within %0d cycles expected pulse", cyc); else passed++;
            if (run == 0) begin
                total++; if (got_key.size() < 1 || got_key[0] !== 64'd0) $display("FAIL k128_k1: got %h expected 0", got_key.size() ? got_key[0] : 64'hx); else passed++;
                total++; if (got_key.size() < 2 || got_key[1] !== K2_128) $display("FAIL k128_k2: got %h expected %h", got_key.size() > 1 ? got_key[1] : 64'hx, K2_128); else passed++;
                total++; if (seq_errors(1'b0) != 0) $display("FAIL k128_fwd_seq: got %0d bad keys expected 0", seq_errors(1'b0)); else passed++;
            end else begin
                total++; if (seq_errors(1'b1) != 0) $display("FAIL k128_rev_seq: got %0d bad keys expected 0", seq_errors(1'b1)); else passed++;
            end
        end
        if128.rk_ready = 1'b0;
    endtask

    task automatic test_rev_vectors;
        collect80(80'd0, 1'b1, 0, 0, 0, 0, 1'b0);
        compute_ref(128'd0, 80);
        total++; if (timed_out != 0) $display("FAIL rev_timeout: got %0d expected 0", timed_out); else passed++;
        total++; if (lat != 33) $display("FAIL rev_latency: got %0d expected 33", lat); else passed++;
        total++; if (got_key.size() != 32) $display("FAIL rev_count: got %0d expected 32", got_key.size()); else passed++;
        if (got_key.size() == 32) begin
            total++; if (got_idx[0] !== 6'd32 || got_idx[31] !== 6'd1) $display("FAIL rev_idx_ends: got %0d..%0d expected 32..1", got_idx[0], got_idx[31]); else passed++;
            total++; if (got_key[29] !== K3_80) $display("FAIL rev_k3: got %h expected %h", got_key[29], K3_80); else passed++;
            total++; if (got_key[30] !== K2_80) $display("FAIL rev_k2: got %h expected %h", got_key[30], K2_80); else passed++;
            total++; if (got_key[31] !== 64'd0) $display("FAIL rev_k1: got %h expected 0", got_key[31]); else passed++;
        end
        total++; if (seq_errors(1'b1) != 0) $display("FAIL rev_seq: got %0d bad keys expected 0", seq_errors(1'b1)); else passed++;
        total++; if (last_hs != 64) $display("FAIL rev_rate: got last handshake cycle %0d expected 64", last_hs); else passed++;
        total++; if (done_cnt != 1 || done_final !== 1'b1 || busy_final !== 1'b0)
            $display("FAIL rev_done: got pulses %0d done %b busy %b expected 1 1 0", done_cnt, done_final, busy_final); else passed++;
    endtask

    task automatic test_stall;
        logic [79:0] key;
        for (int m = 0; m < 2; m++) begin
            key = 80'({$urandom(), $urandom(), $urandom()});
            collect80(key, m[0], 30, 7, 0, 0, 1'b0);
            compute_ref(128'(key), 80);
            total++; if (timed_out != 0) $display("FAIL stall_timeout: got %0d expected 0 mode %0d", timed_out, m); else passed++;
            total++; if (stab_err != 0) $display("FAIL stall_stable: got %0d changes expected 0 mode %0d", stab_err, m); else passed++;
            total++; if (seq_errors(m[0]) != 0) $display("FAIL stall_seq: got %0d bad keys expected 0 mode %0d", seq_errors(m[0]), m); else passed++;
        end
    endtask

    task automatic test_load_busy;
        logic [79:0] ka, kb;
        ka = 80'({$urandom(), $urandom(), $urandom()});
        kb = 80'({$urandom(), $urandom(), $urandom()});
        collect80(ka, 1'b0, 0, 0, 10, 0, 1'b0);
        compute_ref(128'(ka), 80);
        total++; if (seq_errors(1'b0) != 0) $display("FAIL busy_load_ignored: got %0d bad keys expected 0", seq_errors(1'b0)); else passed++;
        total++; if (done_final !== 1'b1 || busy_final !== 1'b0) $display("FAIL busy_load_done: got done %b busy %b expected 1 0", done_final, busy_final); else passed++;
        collect80(kb, 1'b1, 20, 0, 0, 0, 1'b1);
        compute_ref(128'(kb), 80);
        total++; if (lat != 33) $display("FAIL done_cycle_load_latency: got %0d expected 33", lat); else passed++;
        total++; if (seq_errors(1'b1) != 0) $display("FAIL done_cycle_load_seq: got %0d bad keys expected 0", seq_errors(1'b1)); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [79:0] key;
        for (int m = 0; m < 2; m++) begin
            key = 80'({$urandom(), $urandom(), $urandom()});
            // reverse run stopped inside EXPAND; forward run stopped at idx 12
            collect80(key, (m == 0), 0, 0, 0, (m == 0) ? 10 : 12, 1'b0);
            if (m == 0) begin
                total++; if (if80.busy !== 1'b1 || if80.rk_valid !== 1'b0) $display("FAIL midrst_pre_expand: got busy %b valid %b expected 1 0", if80.busy, if80.rk_valid); else passed++;
            end else begin
                total++; if (if80.rk_idx !== 6'd12) $display("FAIL midrst_pre_fwd: got idx %0d expected 12", if80.rk_idx); else passed++;
            end
            rst_n = 1'b0;
            #1;
            total++; if ({if80.rk_valid, if80.busy, if80.done} !== 3'b000) $display("FAIL midrst_ctrl: got %b expected 000 case %0d", {if80.rk_valid, if80.busy, if80.done}, m); else passed++;
            total++; if (if80.rk_data !== 64'd0 || if80.rk_idx !== 6'd0) $display("FAIL midrst_data: got %h/%0d expected 0/0 case %0d", if80.rk_data, if80.rk_idx, m); else passed++;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            total++; if (if80.done !== 1'b0 || if80.busy !== 1'b0) $display("FAIL midrst_no_done: got done %b busy %b expected 0 0 case %0d", if80.done, if80.busy, m); else passed++;
        end
        key = 80'({$urandom(), $urandom(), $urandom()});
        collect80(key, 1'b0, 0, 0, 0, 0, 1'b0);
        compute_ref(128'(key), 80);
        total++; if (got_key.size() < 1 || got_key[0] !== key[79:16]) $display("FAIL midrst_k1: got %h expected %h", got_key.size() ? got_key[0] : 64'hx, key[79:16]); else passed++;
        total++; if (seq_errors(1'b0) != 0) $display("FAIL midrst_seq: got %0d bad keys expected 0", seq_errors(1'b0)); else passed++;
    endtask

    task automatic test_random;
        logic [79:0] key;
        int errs;
        for (int n = 0; n < 200; n++) begin
            key = 80'({$urandom(), $urandom(), $urandom()});
            collect80(key, n[0], 25, 0, 0, 0, 1'b0);
            compute_ref(128'(key), 80);
            errs = seq_errors(n[0]) + timed_out + stab_err;
            total++; if (errs != 0) $display("FAIL random_run: got %0d errors expected 0 run %0d key %h mode %0d", errs, n, key, n[0]); else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        if80.key_in = '0;   if80.key_load = 1'b0;  if80.mode = 1'b0;  if80.rk_ready = 1'b0;
        if128.key_in = '0;  if128.key_load = 1'b0; if128.mode = 1'b0; if128.rk_ready = 1'b0;
        test_reset;
        test_fwd_vectors;
        test_128;
        test_rev_vectors;
        test_stall;
        test_load_busy;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
